// File: rtl/capture_controller.sv
// Purpose: command FSM for the logic analyzer; decodes SUMP opcodes into config registers, arms/counts capture, sequences readout.
// Latency: config register writes visible two cycles after cmd_recv_rx; all outputs registered.
// Backpressure: read_req is held off while transmit_busy is high and idles one cycle after each pulse; META_WAIT waits on meta_busy.
module capture_controller #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int NUM_STAGES   = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                               clock,
    input  logic                               ext_reset,
    input  logic [7:0]                         opcode,
    input  logic [31:0]                        command,
    input  logic                               cmd_recv_rx,
    input  logic                               run,
    input  logic                               sample_tick,
    input  logic                               transmit_busy,
    input  logic                               meta_busy,
    output logic                               reset,
    output logic [23:0]                        divider,
    output logic                               data_meta_mux,
    output logic                               arm,
    output logic                               send_id,
    output logic                               begin_meta_transmit,
    output logic                               read_req,
    output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] rise_pattern,
    output logic [NUM_STAGES*SAMPLE_WIDTH-1:0] fall_pattern
);

    typedef enum logic [2:0] {
        RESETS,
        IDLE,
        DECODE,
        META_WAIT,
        ARMED,
        CAPTURE,
        READOUT
    } state_t;

    state_t                 state;
    logic [7:0]             op_q;
    logic [31:0]            arg_q;
    logic [COUNT_WIDTH-1:0] delay_count;
    logic [COUNT_WIDTH-1:0] read_count;
    logic [COUNT_WIDTH-1:0] sample_cnt;
    logic [COUNT_WIDTH-1:0] read_cnt;
    logic                   meta_first;
    logic                   abort;

    // A reset opcode arriving outside IDLE aborts the current operation.
    assign abort = cmd_recv_rx && (opcode == 8'h00);

    // Command FSM: decode, configuration registers, capture counting and readout pacing.
    always_ff @(posedge clock or posedge ext_reset) begin
        if (ext_reset) begin
            state               <= RESETS;
            op_q                <= '0;
            arg_q               <= '0;
            delay_count         <= '0;
            read_count          <= '0;
            sample_cnt          <= '0;
            read_cnt            <= '0;
            meta_first          <= 1'b0;
            reset               <= 1'b0;
            divider             <= '0;
            data_meta_mux       <= 1'b0;
            arm                 <= 1'b0;
            send_id             <= 1'b0;
            begin_meta_transmit <= 1'b0;
            read_req            <= 1'b0;
            rise_pattern        <= '0;
            fall_pattern        <= '0;
        end else begin
            // Pulse outputs are single-cycle unless a state re-asserts them.
            reset               <= 1'b0;
            send_id             <= 1'b0;
            begin_meta_transmit <= 1'b0;
            read_req            <= 1'b0;

            case (state)
                RESETS: begin
                    reset         <= 1'b1;
                    divider       <= '0;
                    rise_pattern  <= '0;
                    fall_pattern  <= '0;
                    delay_count   <= '0;
                    read_count    <= '0;
                    arm           <= 1'b0;
                    data_meta_mux <= 1'b0;
                    state         <= IDLE;
                end

                IDLE: begin
                    if (cmd_recv_rx) begin
                        op_q  <= opcode;
                        arg_q <= command;
                        state <= DECODE;
                    end
                end

                DECODE: begin
                    state <= IDLE;
                    case (op_q)
                        8'h00: state <= RESETS;
                        8'h01: begin
                            arm   <= 1'b1;
                            state <= ARMED;
                        end
                        8'h02, 8'h04: begin
                            begin_meta_transmit <= 1'b1;
                            send_id             <= (op_q == 8'h02);
                            data_meta_mux       <= 1'b0;
                            meta_first          <= 1'b1;
                            state               <= META_WAIT;
                        end
                        8'h80: divider <= arg_q[23:0];
                        8'h81: begin
                            read_count  <= COUNT_WIDTH'(arg_q[31:16]);
                            delay_count <= COUNT_WIDTH'(arg_q[15:0]);
                        end
                        default: begin
                            // Stage s owns opcodes 0xC0+4s (rise) and 0xC1+4s (fall); others fall through.
                            for (int s = 0; s < NUM_STAGES; s++) begin
                                if (op_q == (8'hC0 + 8'(4 * s)))
                                    rise_pattern[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= arg_q[SAMPLE_WIDTH-1:0];
                                if (op_q == (8'hC1 + 8'(4 * s)))
                                    fall_pattern[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= arg_q[SAMPLE_WIDTH-1:0];
                            end
                        end
                    endcase
                end

                META_WAIT: begin
                    // First cycle ignores meta_busy: the meta unit needs a cycle to raise it.
                    if (abort) begin
                        state <= RESETS;
                    end else if (meta_first) begin
                        meta_first <= 1'b0;
                    end else if (!meta_busy) begin
                        state <= IDLE;
                    end
                end

                ARMED: begin
                    if (abort) begin
                        arm   <= 1'b0;
                        state <= RESETS;
                    end else if (run) begin
                        arm        <= 1'b0;
                        sample_cnt <= '0;
                        state      <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (abort) begin
                        state <= RESETS;
                    end else if (sample_cnt == delay_count) begin
                        data_meta_mux <= 1'b1;
                        read_cnt      <= '0;
                        state         <= READOUT;
                    end else if (sample_tick) begin
                        sample_cnt <= sample_cnt + COUNT_WIDTH'(1);
                    end
                end

                READOUT: begin
                    // A request cycle is always followed by one idle cycle.
                    if (abort) begin
                        data_meta_mux <= 1'b0;
                        state         <= RESETS;
                    end else if (read_req) begin
                        read_req <= 1'b0;
                    end else if (read_cnt == read_count) begin
                        if (!transmit_busy) begin
                            data_meta_mux <= 1'b0;
                            state         <= IDLE;
                        end
                    end else if (!transmit_busy) begin
                        read_req <= 1'b1;
                        read_cnt <= read_cnt + COUNT_WIDTH'(1);
                    end
                end

                default: state <= RESETS;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// Purpose: self-checking bench for capture_controller: config vectors, randomized config and capture sessions, abort/reset corners.
// Latency: commands are sampled one edge after being driven; outputs are read 1 ns after each rising edge.
// Backpressure: transmit_busy is modelled as a transmitter busy for a random time after each read_req plus random blips.
module tb_capture_controller;

    logic        clock;
    logic        ext_reset;
    logic [7:0]  opcode;
    logic [31:0] command;
    logic        cmd_recv_rx;
    logic        run;
    logic        sample_tick;
    logic        transmit_busy;
    logic        meta_busy;
    logic        reset;
    logic [23:0] divider;
    logic        data_meta_mux;
    logic        arm;
    logic        send_id;
    logic        begin_meta_transmit;
    logic        read_req;
    logic [31:0] rise_pattern;
    logic [31:0] fall_pattern;

    int checks = 0;
    int errors = 0;

    capture_controller dut (
        .clock               (clock),
        .ext_reset           (ext_reset),
        .opcode              (opcode),
        .command             (command),
        .cmd_recv_rx         (cmd_recv_rx),
        .run                 (run),
        .sample_tick         (sample_tick),
        .transmit_busy       (transmit_busy),
        .meta_busy           (meta_busy),
        .reset               (reset),
        .divider             (divider),
        .data_meta_mux       (data_meta_mux),
        .arm                 (arm),
        .send_id             (send_id),
        .begin_meta_transmit (begin_meta_transmit),
        .read_req            (read_req),
        .rise_pattern        (rise_pattern),
        .fall_pattern        (fall_pattern)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] arg;
        logic [23:0] div;
        logic [31:0] rise;
        logic [31:0] fall;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a one-cycle command pulse; returns just after the edge that sampled it.
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg);
        opcode      = op;
        command     = arg;
        cmd_recv_rx = 1'b1;
        tick();
        cmd_recv_rx = 1'b0;
    endtask

    // Full capture: program counts, arm, fire, feed ticks and check readout rules.
    task automatic session(input int dl, input int rd);
        int delivered;
        int reqs;
        int busy_left;
        bit saw;
        bit done;
        bit prev_req;
        bit pre_tick;
        bit pre_busy;
        send_cmd(8'h81, {16'(rd), 16'(dl)});
        tick();
        send_cmd(8'h01, 32'h0);
        tick();
        chk("arm_set", 64'(arm), 64'd1);
        for (int i = 0; i < 3; i++) begin
            sample_tick = 1'($urandom_range(0, 1));
            tick();
            chk("arm_hold", 64'(arm), 64'd1);
        end
        sample_tick = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("arm_drop", 64'(arm), 64'd0);
        delivered = 0; reqs = 0; busy_left = 0; saw = 0; done = 0; prev_req = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            sample_tick   = (delivered < dl) && ($urandom_range(0, 1) == 1);
            transmit_busy = (busy_left > 0) || ($urandom_range(0, 5) == 0);
            pre_tick = sample_tick;
            pre_busy = transmit_busy;
            tick();
            if (delivered < dl)
                chk("early_readout", 64'({data_meta_mux, read_req}), 64'd0);
            if (pre_tick) delivered++;
            if (busy_left > 0) busy_left--;
            if (read_req) begin
                reqs++;
                chk("req_while_busy", 64'(pre_busy), 64'd0);
                chk("req_no_gap", 64'(prev_req), 64'd0);
                chk("req_mux", 64'(data_meta_mux), 64'd1);
                busy_left = $urandom_range(0, 3);
            end
            if (data_meta_mux) begin
                saw = 1;
            end else if (saw) begin
                chk("done_while_busy", 64'(pre_busy), 64'd0);
                chk("req_count", 64'(reqs), 64'(rd));
                done = 1;
            end
            prev_req = read_req;
        end
        sample_tick   = 1'b0;
        transmit_busy = 1'b0;
        chk("session_done", 64'(done), 64'd1);
    endtask

    initial begin
        logic [23:0] m_div;
        logic [31:0] m_rise;
        logic [31:0] m_fall;
        logic [7:0]  op;
        logic [31:0] arg;
        int          k;
        bit          found;

        ext_reset = 1'b1; opcode = '0; command = '0; cmd_recv_rx = 1'b0;
        run = 1'b0; sample_tick = 1'b0; transmit_busy = 1'b0; meta_busy = 1'b0;

        vt[0] = '{8'h80, 32'h0000_0123, 24'h000123, 32'h0000_0000, 32'h0000_0000};
        vt[1] = '{8'hC4, 32'h0000_005A, 24'h000123, 32'h0000_5A00, 32'h0000_0000};
        vt[2] = '{8'hD0, 32'h0000_00FF, 24'h000123, 32'h0000_5A00, 32'h0000_0000};
        vt[3] = '{8'hC1, 32'h0000_00A5, 24'h000123, 32'h0000_5A00, 32'h0000_00A5};
        vt[4] = '{8'hCD, 32'h0000_003C, 24'h000123, 32'h0000_5A00, 32'h3C00_00A5};
        vt[5] = '{8'hCC, 32'h1234_5677, 24'h000123, 32'h7700_5A00, 32'h3C00_00A5};
        vt[6] = '{8'h80, 32'hFFAB_CDEF, 24'hABCDEF, 32'h7700_5A00, 32'h3C00_00A5};
        vt[7] = '{8'hC2, 32'h0000_0011, 24'hABCDEF, 32'h7700_5A00, 32'h3C00_00A5};
        vt[8] = '{8'h7F, 32'h0000_0099, 24'hABCDEF, 32'h7700_5A00, 32'h3C00_00A5};
        vt[9] = '{8'hC8, 32'h0000_0042, 24'hABCDEF, 32'h7742_5A00, 32'h3C00_00A5};

        // Reset state and the single-cycle soft reset after release.
        repeat (3) tick();
        chk("rst_divider", 64'(divider), 64'd0);
        chk("rst_arm", 64'(arm), 64'd0);
        chk("rst_mux", 64'(data_meta_mux), 64'd0);
        chk("rst_pulses", 64'({reset, read_req, begin_meta_transmit, send_id}), 64'd0);
        ext_reset = 1'b0;
        tick();
        chk("soft_reset_hi", 64'(reset), 64'd1);
        tick();
        chk("soft_reset_lo", 64'(reset), 64'd0);

        // Configuration vectors.
        for (int i = 0; i < 10; i++) begin
            send_cmd(vt[i].op, vt[i].arg);
            tick();
            chk("vec_divider", 64'(divider), 64'(vt[i].div));
            chk("vec_rise", 64'(rise_pattern), 64'(vt[i].rise));
            chk("vec_fall", 64'(fall_pattern), 64'(vt[i].fall));
        end

        // Randomized configuration against an opcode-rule model.
        m_div = vt[9].div; m_rise = vt[9].rise; m_fall = vt[9].fall;
        for (int i = 0; i < 30; i++) begin
            op  = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(8'hBC, 8'hD3));
            arg = $urandom;
            k   = int'(op) - 'hC0;
            if (op == 8'h80) m_div = arg[23:0];
            else if (k >= 0 && k < 16 && (k % 4) == 0) m_rise[(k / 4) * 8 +: 8] = arg[7:0];
            else if (k >= 0 && k < 16 && (k % 4) == 1) m_fall[(k / 4) * 8 +: 8] = arg[7:0];
            send_cmd(op, arg);
            tick();
            chk("rnd_divider", 64'(divider), 64'(m_div));
            chk("rnd_rise", 64'(rise_pattern), 64'(m_rise));
            chk("rnd_fall", 64'(fall_pattern), 64'(m_fall));
        end

        // Abort in ARMED coinciding with run: reset wins, no capture.
        send_cmd(8'hC0, 32'hFF);
        tick();
        send_cmd(8'h01, 32'h0);
        tick();
        chk("abort_armed", 64'(arm), 64'd1);
        opcode = 8'h00; command = '0; cmd_recv_rx = 1'b1; run = 1'b1;
        tick();
        cmd_recv_rx = 1'b0; run = 1'b0;
        chk("abort_arm_drop", 64'(arm), 64'd0);
        tick();
        chk("abort_reset_pulse", 64'(reset), 64'd1);
        chk("abort_rise_clr", 64'(rise_pattern), 64'd0);
        chk("abort_fall_clr", 64'(fall_pattern), 64'd0);
        chk("abort_div_clr", 64'(divider), 64'd0);
        tick();
        chk("abort_reset_end", 64'(reset), 64'd0);
        sample_tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_capture", 64'({data_meta_mux, read_req}), 64'd0);
        end
        sample_tick = 1'b0;

        // Metadata / ID transmission.
        send_cmd(8'h02, 32'h0);
        tick();
        chk("id_begin", 64'(begin_meta_transmit), 64'd1);
        chk("id_send_id", 64'(send_id), 64'd1);
        chk("id_mux", 64'(data_meta_mux), 64'd0);
        meta_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("id_single_pulse", 64'({begin_meta_transmit, send_id}), 64'd0);
        end
        meta_busy = 1'b0;
        tick();
        send_cmd(8'h04, 32'h0);
        tick();
        chk("meta_begin", 64'(begin_meta_transmit), 64'd1);
        chk("meta_send_id", 64'(send_id), 64'd0);
        // meta_busy low on the first waiting cycle must not end the wait.
        tick();
        meta_busy = 1'b1;
        send_cmd(8'h80, 32'h55);
        tick();
        tick();
        meta_busy = 1'b0;
        tick();
        tick();
        chk("meta_latency_tolerated", 64'(divider), 64'd0);
        // Abort while waiting on the meta unit.
        send_cmd(8'h02, 32'h0);
        tick();
        meta_busy = 1'b1;
        send_cmd(8'h00, 32'h0);
        meta_busy = 1'b0;
        tick();
        chk("meta_abort_reset", 64'(reset), 64'd1);
        tick();

        // Capture sessions: directed corners, then random.
        session(2, 3);
        session(0, 0);
        session(0, 2);
        session(3, 0);
        for (int i = 0; i < 16; i++)
            session($urandom_range(0, 5), $urandom_range(0, 4));

        // ext_reset mid-readout after the first request.
        send_cmd(8'h80, 32'h00BEEF);
        tick();
        chk("t6_div_set", 64'(divider), 64'h00BEEF);
        send_cmd(8'h81, {16'd4, 16'd1});
        tick();
        send_cmd(8'h01, 32'h0);
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (read_req) found = 1;
        end
        chk("t6_first_req", 64'(found), 64'd1);
        ext_reset = 1'b1;
        #1;
        chk("t6_req_clr", 64'(read_req), 64'd0);
        chk("t6_mux_clr", 64'(data_meta_mux), 64'd0);
        chk("t6_div_clr", 64'(divider), 64'd0);
        chk("t6_arm_clr", 64'(arm), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_held_no_req", 64'(read_req), 64'd0);
        end
        ext_reset = 1'b0;
        tick();
        chk("t6_soft_reset", 64'(reset), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t6_no_req", 64'({read_req, data_meta_mux}), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
